control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; port list as follows.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 instr  input  16  instruction word from instruction memory at current PC.
REQ-005 pc_clr  output  1  synchronous clear to program counter.
REQ-006 pc_up  output  1  increment program counter.
REQ-007 ir_ld  output  1  IR load strobe (visible for debug).
REQ-008 d_addr  output  8  data memory address.
REQ-009 d_wr  output  1  data memory write enable.
REQ-010 rf_s  output  1  RF write-data mux; 1 = data memory, 0 = ALU.
REQ-011 rf_w_addr  output  4  RF write address.
REQ-012 rf_w_en  output  1  RF write enable.
REQ-013 rf_ra_addr, rf_rb_addr  output  4 each  RF read addresses.
REQ-014 alu_s  output  3  ALU op: 000 pass A, 001 add, 010 subtract.
REQ-015 halted  output  1  high while in HALT state.
REQ-016 Parameter IW, default 16, instruction width; only 16 is supported.

Function
REQ-017 States: INIT, FETCH, DECODE, NOOP, LOAD_A, LOAD_B, STORE, ADD, SUB, HALT.
REQ-018 Transitions: INIT->FETCH; FETCH->DECODE; DECODE->state by opcode IR[15:12]; NOOP, LOAD_B, STORE, ADD, SUB->FETCH; LOAD_A->LOAD_B; HALT->HALT.
REQ-019 Opcodes: 0000 NOOP, 0001 STORE, 0010 LOAD, 0011 ADD, 0100 SUB, 0101 HALT; 0110-1111 decode to NOOP.
REQ-020 Internal 16-bit IR captures instr on the clock edge ending FETCH; IR is held in all other states.
REQ-021 INIT: pc_clr=1. FETCH: ir_ld=1, pc_up=1. pc_up is never asserted in any other state.
REQ-022 LOAD_A: d_addr=IR[11:4], rf_s=1, rf_w_addr=IR[3:0], rf_w_en=0. LOAD_B: same values with rf_w_en=1.
REQ-023 STORE: d_addr=IR[7:0], rf_ra_addr=IR[11:8], alu_s=000, d_wr=1.
REQ-024 ADD/SUB: rf_ra_addr=IR[11:8], rf_rb_addr=IR[7:4], rf_w_addr=IR[3:0], rf_s=0, rf_w_en=1, alu_s=001/010.
REQ-025 Every output not listed for the current state SHALL be 0; outputs are combinational functions of state and IR only (no dependence on instr).
REQ-026 Instruction latency: NOOP, STORE, ADD, SUB take 3 cycles; LOAD takes 4 cycles; FETCH to FETCH.
REQ-027 HALT is sticky: all strobes 0 and halted=1 until reset; PC is not advanced.
REQ-028 PC wrap (127->0) is the counter's concern; the controller treats the wrapped address as normal.

Reset
REQ-029 reset asserted, at any state including mid-LOAD: state=INIT and IR=0 immediately, asynchronously; d_wr and rf_w_en drop to 0 immediately.
REQ-030 While reset is high, pc_clr=1 and all other outputs are 0; first FETCH follows one INIT cycle after reset deasserts.

Structure
REQ-031 Opcode constants and the state enum SHALL live in a shared package projb_pkg, reused by the top level and benches.
REQ-032 No sub-module is required; the IR may be split out as sub-module ir_reg if reused.

Verification
REQ-033 Reset, then release -> pc_clr=1 for exactly one cycle, then FETCH with pc_up=1, ir_ld=1.
REQ-034 instr=16'h2 1A 3 (LOAD) -> LOAD_A d_addr=8'h1A, rf_w_addr=3, rf_s=1; LOAD_B rf_w_en=1 for one cycle; 4 cycles total.
REQ-035 instr=16'h3125 (ADD) -> ra=1, rb=2, rf_w_addr=5, alu_s=001, rf_w_en=1 one cycle; 16'h4125 gives alu_s=010.
REQ-036 instr=16'h1705 (STORE) -> d_addr=8'h05, rf_ra_addr=7, d_wr=1 for one cycle, rf_w_en=0.
REQ-037 instr=16'h5000 (HALT) -> halted=1, pc_up stays 0 for 20+ cycles; reset returns to INIT. Opcode 4'hF behaves as NOOP.
REQ-038 Assert reset during LOAD_B -> rf_w_en falls before the next clock edge; after release, sequence restarts at INIT.

Source files
------------

// File: rtl/projb_pkg.sv
// Shared opcode constants, controller state enum and decode helper for the
// single-cycle-per-state control unit.
package projb_pkg;

  localparam int IR_W = 16;

  localparam logic [3:0] OP_NOOP  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_LOAD  = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_HALT  = 4'b0101;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;

  typedef enum logic [3:0] {
    S_INIT, S_FETCH, S_DECODE, S_NOOP, S_LOAD_A,
    S_LOAD_B, S_STORE, S_ADD, S_SUB, S_HALT
  } state_t;

  typedef struct packed {
    logic       pc_clr;
    logic       pc_up;
    logic       ir_ld;
    logic [7:0] d_addr;
    logic       d_wr;
    logic       rf_s;
    logic [3:0] rf_w_addr;
    logic       rf_w_en;
    logic [3:0] rf_ra_addr;
    logic [3:0] rf_rb_addr;
    logic [2:0] alu_s;
    logic       halted;
  } ctrl_t;

  // Unused opcodes fall through to NOOP so stray words never stall the core.
  function automatic state_t decode_op(input logic [3:0] op);
    case (op)
      OP_STORE: decode_op = S_STORE;
      OP_LOAD:  decode_op = S_LOAD_A;
      OP_ADD:   decode_op = S_ADD;
      OP_SUB:   decode_op = S_SUB;
      OP_HALT:  decode_op = S_HALT;
      default:  decode_op = S_NOOP;
    endcase
  endfunction

endpackage

// File: rtl/ir_reg.sv
// Instruction register: loads on ld, clears asynchronously on reset.
module ir_reg #(
  parameter int IW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld,
  input  logic [IW-1:0] d,
  output logic [IW-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   q <= '0;
    else if (ld) q <= d;
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle controller: FETCH/DECODE/execute sequencing with outputs
// decoded purely from state and IR so reset kills strobes immediately.
module control_unit
  import projb_pkg::*;
#(
  parameter int IW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] instr,
  output logic          pc_clr,
  output logic          pc_up,
  output logic          ir_ld,
  output logic [7:0]    d_addr,
  output logic          d_wr,
  output logic          rf_s,
  output logic [3:0]    rf_w_addr,
  output logic          rf_w_en,
  output logic [3:0]    rf_ra_addr,
  output logic [3:0]    rf_rb_addr,
  output logic [2:0]    alu_s,
  output logic          halted
);

  state_t        state;
  logic [IW-1:0] ir;
  ctrl_t         ctl;

  ir_reg #(.IW(IW)) u_ir (
    .clk   (clk),
    .reset (reset),
    .ld    (state == S_FETCH),
    .d     (instr),
    .q     (ir)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_INIT;
    else begin
      case (state)
        S_INIT:   state <= S_FETCH;
        S_FETCH:  state <= S_DECODE;
        S_DECODE: state <= decode_op(ir[15:12]);
        S_LOAD_A: state <= S_LOAD_B;
        S_HALT:   state <= S_HALT;
        default:  state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    ctl = '0;
    case (state)
      S_INIT:  ctl.pc_clr = 1'b1;
      S_FETCH: begin
        ctl.ir_ld = 1'b1;
        ctl.pc_up = 1'b1;
      end
      S_LOAD_A, S_LOAD_B: begin
        ctl.d_addr    = ir[11:4];
        ctl.rf_s      = 1'b1;
        ctl.rf_w_addr = ir[3:0];
        ctl.rf_w_en   = (state == S_LOAD_B);
      end
      S_STORE: begin
        ctl.d_addr     = ir[7:0];
        ctl.rf_ra_addr = ir[11:8];
        ctl.alu_s      = ALU_PASS;
        ctl.d_wr       = 1'b1;
      end
      S_ADD, S_SUB: begin
        ctl.rf_ra_addr = ir[11:8];
        ctl.rf_rb_addr = ir[7:4];
        ctl.rf_w_addr  = ir[3:0];
        ctl.rf_w_en    = 1'b1;
        ctl.alu_s      = (state == S_ADD) ? ALU_ADD : ALU_SUB;
      end
      S_HALT:  ctl.halted = 1'b1;
      default: ctl = '0;
    endcase
  end

  assign pc_clr     = ctl.pc_clr;
  assign pc_up      = ctl.pc_up;
  assign ir_ld      = ctl.ir_ld;
  assign d_addr     = ctl.d_addr;
  assign d_wr       = ctl.d_wr;
  assign rf_s       = ctl.rf_s;
  assign rf_w_addr  = ctl.rf_w_addr;
  assign rf_w_en    = ctl.rf_w_en;
  assign rf_ra_addr = ctl.rf_ra_addr;
  assign rf_rb_addr = ctl.rf_rb_addr;
  assign alu_s      = ctl.alu_s;
  assign halted     = ctl.halted;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle output vectors checked at negedge.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] instr = 16'h0000;
  logic        pc_clr, pc_up, ir_ld, d_wr, rf_s, rf_w_en, halted;
  logic [7:0]  d_addr;
  logic [3:0]  rf_w_addr, rf_ra_addr, rf_rb_addr;
  logic [2:0]  alu_s;
  logic [29:0] outs;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  control_unit #(.IW(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .pc_clr     (pc_clr),
    .pc_up      (pc_up),
    .ir_ld      (ir_ld),
    .d_addr     (d_addr),
    .d_wr       (d_wr),
    .rf_s       (rf_s),
    .rf_w_addr  (rf_w_addr),
    .rf_w_en    (rf_w_en),
    .rf_ra_addr (rf_ra_addr),
    .rf_rb_addr (rf_rb_addr),
    .alu_s      (alu_s),
    .halted     (halted)
  );

  assign outs = {pc_clr, pc_up, ir_ld, d_addr, d_wr, rf_s, rf_w_addr,
                 rf_w_en, rf_ra_addr, rf_rb_addr, alu_s, halted};

  function automatic logic [29:0] mk(
    input logic clr, input logic up, input logic ld, input logic [7:0] da,
    input logic wr, input logic s, input logic [3:0] wa, input logic we,
    input logic [3:0] ra, input logic [3:0] rb, input logic [2:0] alu,
    input logic h);
    mk = {clr, up, ld, da, wr, s, wa, we, ra, rb, alu, h};
  endfunction

  localparam logic [29:0] V_ZERO  = 30'h0;
  localparam logic [29:0] V_INIT  = 30'h2000_0000;
  localparam logic [29:0] V_FETCH = 30'h1800_0000;
  localparam logic [29:0] V_HALT  = 30'h0000_0001;

  task automatic chk(input string tag, input logic [29:0] got, input logic [29:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  // Called at a negedge while in FETCH; presents the word, then scrambles
  // instr so any dependence on the live bus shows up.
  task automatic issue(input logic [15:0] w);
    chk("fetch", outs, V_FETCH);
    instr = w;
    tick();
    instr = 16'hFFFF;
    chk("decode", outs, V_ZERO);
    tick();
  endtask

  initial begin
    reset = 1'b1;
    tick(); tick();
    chk("reset_hold", outs, V_INIT);
    reset = 1'b0;
    #1 chk("init_after_release", outs, V_INIT);
    tick();

    // LOAD 0x21A3: two exec cycles, write only in LOAD_B
    issue(16'h21A3);
    chk("load_a", outs, mk(0,0,0,8'h1A,0,1,4'h3,0,4'h0,4'h0,3'b000,0));
    tick();
    chk("load_b", outs, mk(0,0,0,8'h1A,0,1,4'h3,1,4'h0,4'h0,3'b000,0));
    tick();

    issue(16'h3125);
    chk("add", outs, mk(0,0,0,8'h00,0,0,4'h5,1,4'h1,4'h2,3'b001,0));
    tick();

    issue(16'h4125);
    chk("sub", outs, mk(0,0,0,8'h00,0,0,4'h5,1,4'h1,4'h2,3'b010,0));
    tick();

    issue(16'h1705);
    chk("store", outs, mk(0,0,0,8'h05,1,0,4'h0,0,4'h7,4'h0,3'b000,0));
    tick();

    issue(16'hF000);
    chk("noop_f", outs, V_ZERO);
    tick();

    issue(16'h0ABC);
    chk("noop_0", outs, V_ZERO);
    tick();

    // Reset mid-LOAD_B must drop rf_w_en before the next edge
    issue(16'h2FF9);
    chk("load_a2", outs, mk(0,0,0,8'hFF,0,1,4'h9,0,4'h0,4'h0,3'b000,0));
    tick();
    chk("load_b2", outs, mk(0,0,0,8'hFF,0,1,4'h9,1,4'h0,4'h0,3'b000,0));
    reset = 1'b1;
    #1 chk("async_reset", outs, V_INIT);
    tick();
    chk("reset_hold2", outs, V_INIT);
    reset = 1'b0;
    #1 chk("init_after_release2", outs, V_INIT);
    tick();

    issue(16'h5000);
    for (int i = 0; i < 22; i++) begin
      chk($sformatf("halt_%0d", i), outs, V_HALT);
      tick();
    end

    reset = 1'b1;
    #1 chk("halt_reset", outs, V_INIT);
    tick();
    reset = 1'b0;
    tick();

    // IR cleared by reset: a HALT word left over must not reappear
    issue(16'h3ABC);
    chk("add_after_halt", outs, mk(0,0,0,8'h00,0,0,4'hC,1,4'hA,4'hB,3'b001,0));
    tick();
    chk("fetch_final", outs, V_FETCH);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
